// File: rtl/snn_pkg.sv
// Shared definitions for the SNN neuron/decoder blocks: decode FSM states,
// default field widths and a width helper for index ports.
package snn_pkg;

   localparam int DEF_CNT_W = 8;
   localparam int DEF_WIN_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      HOLD  = 2'd2
   } snn_state_e;

   // Index width for n channels, never narrower than one bit.
   function automatic int winner_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spike_counter.sv
// Per-channel saturating spike counter with synchronous clear and enable.
// count_next exposes the value the register takes at the coming edge.
module spike_counter
   import snn_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             enable,
   input  logic             spike,
   output logic [CNT_W-1:0] count,
   output logic [CNT_W-1:0] count_next
);

   // NOTE: default assignment first, so no path through this block infers a latch.
   always_comb begin
      count_next = count;
      if (clear)
         count_next = '0;
      else if (enable && spike && (count != '1))
         count_next = count + CNT_W'(1);
   end

   // NOTE: state is updated with non-blocking assignments only, so every
   // register samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (!rst_n)
         count <= '0;
      else
         count <= count_next;
   end

endmodule

// File: rtl/spike_rate_decoder.sv
// Rate decoder: counts spikes per channel over a programmable window, then
// holds counts, winning channel and tie flag until the consumer accepts them.
module spike_rate_decoder
   import snn_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = DEF_CNT_W,
   parameter int WIN_W  = DEF_WIN_W
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_CH-1:0]                 spike_in,
   input  logic [WIN_W-1:0]                  window_len,
   input  logic                              start,
   input  logic                              out_ready,
   output logic                              out_valid,
   output logic [NUM_CH*CNT_W-1:0]           counts,
   output logic [winner_width(NUM_CH)-1:0]   winner,
   output logic                              tie,
   output logic                              busy
);

   localparam int WINNER_W = winner_width(NUM_CH);

   snn_state_e          state_q, state_d;
   logic [WIN_W-1:0]    win_len_q, elapsed_q;
   logic [WINNER_W-1:0] winner_q, winner_d;
   logic                tie_q, tie_d;
   logic                accept, last_cycle, seen;
   logic [CNT_W-1:0]    max_val;
   logic [CNT_W-1:0]    cnt_q [NUM_CH];
   logic [CNT_W-1:0]    cnt_d [NUM_CH];

   assign accept     = (state_q == IDLE) && start;
   // A captured length of 0 wraps to 2^WIN_W cycles through the modular compare.
   assign last_cycle = (state_q == COUNT) && (elapsed_q == win_len_q - WIN_W'(1));

   always_ff @(posedge clk) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start)      state_d = COUNT;
         COUNT:   if (last_cycle) state_d = HOLD;
         HOLD:    if (out_ready)  state_d = IDLE;
         default:                 state_d = IDLE;
      endcase
   end

   always_comb begin
      out_valid = (state_q == HOLD);
      busy      = (state_q == COUNT);
      winner    = winner_q;
      tie       = tie_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         win_len_q <= '0;
         elapsed_q <= '0;
         winner_q  <= '0;
         tie_q     <= 1'b0;
      end else begin
         if (accept) begin
            win_len_q <= window_len;
            elapsed_q <= '0;
         end else if (state_q == COUNT) begin
            elapsed_q <= elapsed_q + WIN_W'(1);
         end
         if (last_cycle) begin
            winner_q <= winner_d;
            tie_q    <= tie_d;
         end
      end
   end

   // Counter registers double as the result registers: they freeze once COUNT ends.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      spike_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk        (clk),
         .rst_n      (rst_n),
         .clear      (accept),
         .enable     (busy),
         .spike      (spike_in[i]),
         .count      (cnt_q[i]),
         .count_next (cnt_d[i])
      );
      assign counts[i*CNT_W +: CNT_W] = cnt_q[i];
   end

   // Compare the post-edge counts so the final sampled spike is included.
   always_comb begin
      max_val  = cnt_d[0];
      winner_d = '0;
      tie_d    = 1'b0;
      seen     = 1'b0;
      for (int i = 1; i < NUM_CH; i++) begin
         if (cnt_d[i] > max_val) begin
            max_val  = cnt_d[i];
            winner_d = WINNER_W'(i);
         end
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (cnt_d[i] == max_val) begin
            if (seen)
               tie_d = 1'b1;
            seen = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Scoreboard bench: two decoders (CNT_W=8 and CNT_W=4) share stimulus; the
// driver queues hand-computed results and a negedge monitor checks transfers.
module tb_spike_rate_decoder;

   logic       clk = 1'b0;
   logic       rst_n, start, out_ready;
   logic [1:0] spike_in;
   logic [7:0] window_len;

   logic        ov8, busy8, tie8, win8;
   logic [15:0] counts8;
   logic        ov4, busy4, tie4, win4;
   logic [7:0]  counts4;

   typedef struct {
      logic [15:0] counts;
      logic        winner;
      logic        tie;
   } exp_t;

   exp_t q8[$];
   exp_t q4[$];
   exp_t e8, e4;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   spike_rate_decoder u_dut8 (
      .clk(clk), .rst_n(rst_n), .spike_in(spike_in), .window_len(window_len),
      .start(start), .out_ready(out_ready), .out_valid(ov8), .counts(counts8),
      .winner(win8), .tie(tie8), .busy(busy8)
   );

   spike_rate_decoder #(.NUM_CH(2), .CNT_W(4), .WIN_W(8)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .spike_in(spike_in), .window_len(window_len),
      .start(start), .out_ready(out_ready), .out_valid(ov4), .counts(counts4),
      .winner(win4), .tie(tie4), .busy(busy4)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [15:0] c, input logic w, input logic t);
      exp_t e;
      e.counts = c;
      e.winner = w;
      e.tie    = t;
      return e;
   endfunction

   // Spike on every p-th cycle of the window, at most n spikes; p=0 means none.
   function automatic logic spk(input int k, input int p, input int n);
      if (p == 0) return 1'b0;
      return ((k % p) == 0) && ((k / p) < n);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: a transfer is out_valid now with out_ready presented for the next edge.
   always @(negedge clk) begin
      if (ov8 && out_ready) begin
         if (q8.size() == 0) begin
            check("dut8 unexpected out_valid", 32'(ov8), 32'd0);
         end else begin
            e8 = q8.pop_front();
            check("dut8 counts", 32'(counts8), 32'(e8.counts));
            check("dut8 winner", 32'(win8), 32'(e8.winner));
            check("dut8 tie", 32'(tie8), 32'(e8.tie));
         end
      end
      if (ov4 && out_ready) begin
         if (q4.size() == 0) begin
            check("dut4 unexpected out_valid", 32'(ov4), 32'd0);
         end else begin
            e4 = q4.pop_front();
            check("dut4 counts", 32'(counts4), 32'(e4.counts[7:0]));
            check("dut4 winner", 32'(win4), 32'(e4.winner));
            check("dut4 tie", 32'(tie4), 32'(e4.tie));
         end
      end
   end

   // Starts a window, drives the spike pattern, checks busy length and result latency.
   task automatic run_window(input int wlen, input int p0, input int n0,
                             input int p1, input int n1, input exp_t x8, input exp_t x4);
      int w;
      int busy_cnt;
      w = (wlen == 0) ? 256 : wlen;
      busy_cnt = 0;
      q8.push_back(x8);
      q4.push_back(x4);
      start      = 1'b1;
      window_len = 8'(wlen);
      spike_in   = 2'b11;
      step();
      start = 1'b0;
      for (int k = 0; k < w; k++) begin
         if (busy8 && busy4 && !ov8 && !ov4) busy_cnt++;
         spike_in = {spk(k, p1, n1), spk(k, p0, n0)};
         step();
      end
      spike_in = 2'b11;
      check("busy cycles", 32'(busy_cnt), 32'(w));
      check("busy after window", 32'({busy8, busy4}), 32'd0);
      check("out_valid at t+W+1", 32'({ov8, ov4}), 32'd3);
      if (out_ready) step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n      = 1'b0;
      start      = 1'b0;
      out_ready  = 1'b1;
      spike_in   = 2'b00;
      window_len = 8'd0;
      repeat (3) step();
      check("reset out_valid", 32'({ov8, ov4}), 32'd0);
      check("reset busy", 32'({busy8, busy4}), 32'd0);
      check("reset counts", 32'({counts8, counts4}), 32'd0);
      check("reset winner", 32'({win8, win4}), 32'd0);
      check("reset tie", 32'({tie8, tie4}), 32'd0);

      // First start coincides with reset release.
      rst_n = 1'b1;
      run_window(10, 1, 10, 2, 5, mk(16'h050A, 1'b0, 1'b0), mk(16'h005A, 1'b0, 1'b0));
      run_window(20, 0, 0, 1, 20, mk(16'h1400, 1'b1, 1'b0), mk(16'h00F0, 1'b1, 1'b0));
      run_window(4, 0, 0, 0, 0, mk(16'h0000, 1'b0, 1'b1), mk(16'h0000, 1'b0, 1'b1));
      run_window(8, 2, 3, 1, 3, mk(16'h0303, 1'b0, 1'b1), mk(16'h0033, 1'b0, 1'b1));

      // Backpressure with a start pulse in HOLD, then start together with out_ready.
      out_ready = 1'b0;
      run_window(5, 1, 5, 0, 0, mk(16'h0005, 1'b0, 1'b0), mk(16'h0005, 1'b0, 1'b0));
      for (int j = 0; j < 7; j++) begin
         check("hold out_valid", 32'({ov8, ov4}), 32'd3);
         check("hold counts", 32'({counts8, counts4}), 32'h0005_05);
         check("hold winner/tie/busy", 32'({win8, tie8, busy8, win4, tie4, busy4}), 32'd0);
         start      = (j == 3);
         window_len = 8'd3;
         step();
      end
      out_ready = 1'b1;
      start     = 1'b1;
      step();
      check("idle after transfer", 32'({ov8, ov4, busy8, busy4}), 32'd0);
      start = 1'b0;
      step();
      check("start with out_ready ignored", 32'({busy8, busy4}), 32'd0);

      // Reset on cycle 3 of a 10-cycle window.
      start      = 1'b1;
      window_len = 8'd10;
      spike_in   = 2'b01;
      step();
      start = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      step();
      check("mid-count reset out_valid/busy", 32'({ov8, ov4, busy8, busy4}), 32'd0);
      check("mid-count reset counts", 32'({counts8, counts4}), 32'd0);
      rst_n = 1'b1;
      run_window(6, 3, 2, 1, 4, mk(16'h0402, 1'b1, 1'b0), mk(16'h0042, 1'b1, 1'b0));

      // window_len=0 means 256 cycles; both widths saturate differently.
      run_window(0, 1, 256, 2, 128, mk(16'h80FF, 1'b0, 1'b0), mk(16'h00FF, 1'b0, 1'b1));

      repeat (3) step();
      check("scoreboard drained", 32'(q8.size() + q4.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
